// File: rtl/mult_ctrl_pkg.sv
// Shared constants for the HI/LO multiply sequencer: op encoding, FSM states, widths.
package mult_ctrl_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PROD_W = 64;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WB   = 2'b10
  } state_e;

endpackage

// File: rtl/mult_sign_fix.sv
// Sign handling around an unsigned multiplier: operand magnitudes in, conditional negate out.
// Ports:
//   a, b       raw request operands
//   is_signed  request is a signed MULT
//   prod       unsigned product from the multiplier
//   neg        registered sign of the in-flight result
//   a_mag      |a| (or a for unsigned), 0x80000000 stays 0x80000000
//   b_mag      |b| (or b for unsigned)
//   neg_c      result sign for the request being accepted
//   result_c   prod, two's-complement negated when neg is set
module mult_sign_fix
  import mult_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              is_signed,
  input  logic [PROD_W-1:0] prod,
  input  logic              neg,
  output logic [WORD_W-1:0] a_mag,
  output logic [WORD_W-1:0] b_mag,
  output logic              neg_c,
  output logic [PROD_W-1:0] result_c
);

  always_comb begin
    a_mag    = (is_signed && a[WORD_W-1]) ? WORD_W'(-a) : a;
    b_mag    = (is_signed && b[WORD_W-1]) ? WORD_W'(-b) : b;
    neg_c    = is_signed && (a[WORD_W-1] ^ b[WORD_W-1]);
    result_c = neg ? PROD_W'(-prod) : prod;
  end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer for the shared 32x32 multiplier: holds operands for LATENCY cycles,
// then writes the product into HI/LO; also handles MTHI/MTLO and HI/LO reads.
// Optional feature macro: MULT_SIGNED_EN (signed MULT via magnitude + negate).
// Ports:
//   clk, reset            clock, async active-high reset
//   req_valid/ready/op    request handshake (ready only in IDLE), op code
//   req_a, req_b          operands / MTHI-MTLO data in req_a
//   flush                 squash the in-flight multiply
//   rd_valid, rd_sel      HI/LO read (sel 1 = HI), rd_data combinational
//   rd_stall, busy, done  pipeline status
//   mul_a, mul_b, mul_p   registered multiplier operands and its product
module mult_hilo_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic              flush,
  input  logic              rd_valid,
  input  logic              rd_sel,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_stall,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] mul_a,
  output logic [WORD_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_p
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WORD_W-1:0] mul_a_d, mul_b_d;
  logic [WORD_W-1:0] op_a_mag, op_b_mag;
  logic [PROD_W-1:0] wb_prod;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d, op_neg;

  mult_sign_fix u_sign_fix (
    .a        (req_a),
    .b        (req_b),
    .is_signed(req_op == OP_MULT),
    .prod     (mul_p),
    .neg      (neg_q),
    .a_mag    (op_a_mag),
    .b_mag    (op_b_mag),
    .neg_c    (op_neg),
    .result_c (wb_prod)
  );
`else
  // MULT is treated as MULTU; operands and product pass straight through.
  assign op_a_mag = req_a;
  assign op_b_mag = req_b;
  assign wb_prod  = mul_p;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a;
    mul_b_d = mul_b;
`ifdef MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // flush is ignored here: it only targets an already accepted multiply.
        if (req_valid) begin
          case (req_op)
            OP_MTHI: hi_d = req_a;
            OP_MTLO: lo_d = req_a;
            default: begin
              mul_a_d = op_a_mag;
              mul_b_d = op_b_mag;
`ifdef MULT_SIGNED_EN
              neg_d   = op_neg;
`endif
              cnt_d   = CNT_W'(LATENCY - 1);
              state_d = ST_RUN;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_WB;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = wb_prod;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a   <= mul_a_d;
      mul_b   <= mul_b_d;
`ifdef MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Status decoded from the state register; done is suppressed by a squash in WB.
  assign busy      = (state_q != ST_IDLE);
  assign req_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_WB) && !flush;
  assign rd_stall  = rd_valid && busy;
  assign rd_data   = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
module tb_mult_hilo_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush, rd_valid, rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall, busy, done;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural HI/LO.
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  // Stand-in for the external combinational multiplier.
  assign mul_p = 64'(mul_a) * 64'(mul_b);

  mult_hilo_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_stall(rd_stall), .busy(busy), .done(done),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string tag);
    rd_valid = 1'b1;
    rd_sel = 1'b0;
    #1 check_eq({tag, "_lo"}, 64'(rd_data), 64'(m_lo));
    check_eq({tag, "_lo_stall"}, 64'(rd_stall), 64'd0);
    rd_sel = 1'b1;
    #1 check_eq({tag, "_hi"}, 64'(rd_data), 64'(m_hi));
    rd_valid = 1'b0;
  endtask

  // Spec-level result of a multiply request.
  function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
    longint sa, sb;
    if (op == 2'b01) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
`endif
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] x);
`ifdef MULT_SIGNED_EN
    if (op == 2'b01 && x[31]) return 32'(0 - x);
`endif
    return x;
  endfunction

  task automatic do_mt(input logic [1:0] op, input logic [31:0] d);
    req_valid = 1'b1; req_op = op; req_a = d; req_b = $urandom;
    step();
    req_valid = 1'b0;
    if (op == 2'b10) m_hi = d; else m_lo = d;
    check_eq("mt_busy", 64'(busy), 64'd0);
    check_hilo("mt");
  endtask

  // Issue a multiply; fa = cycle after accept in which flush is raised (-1 = none).
  task automatic do_mul(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int fa, input logic flush_at_accept);
    int j;
    int dones;
    logic [63:0] p;
    p = ref_prod(op, a, b);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flush = flush_at_accept;
    rd_valid = 1'b1; rd_sel = 1'($urandom);
    #1 check_eq({tag, "_acc_stall"}, 64'(rd_stall), 64'd0);
    check_eq({tag, "_acc_rd"}, 64'(rd_data), 64'(rd_sel ? m_hi : m_lo));
    step();
    req_valid = 1'b0; flush = 1'b0; rd_valid = 1'b0;
    check_eq({tag, "_mul_a"}, 64'(mul_a), 64'(ref_mag(op, a)));
    check_eq({tag, "_mul_b"}, 64'(mul_b), 64'(ref_mag(op, b)));
    j = 0; dones = 0;
    while (busy && j < 20) begin
      flush = (j == fa);
      rd_valid = 1'($urandom);
      #1;
      if (done) dones++;
      if (rd_valid) check_eq({tag, "_run_stall"}, 64'(rd_stall), 64'd1);
      step();
      j++;
    end
    flush = 1'b0; rd_valid = 1'b0;
    check_eq({tag, "_busy_cycles"}, 64'(j), (fa < 0) ? 64'(LAT + 1) : 64'(fa + 1));
    check_eq({tag, "_done_cnt"}, 64'(dones), (fa < 0) ? 64'd1 : 64'd0);
    if (fa < 0) {m_hi, m_lo} = p;
    check_hilo(tag);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    flush = 1'b0; rd_valid = 1'b0; rd_sel = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_mul_a", 64'(mul_a), 64'd0);
    check_eq("rst_mul_b", 64'(mul_b), 64'd0);
    check_hilo("rst");
    @(negedge clk);
    reset = 1'b0;
    step();

    // Directed cases.
    do_mul("ff_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check_eq("ff_ff_hi_const", 64'(m_hi), 64'hFFFF_FFFE);
    do_mul("mult_m1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, -1, 1'b0);
    do_mul("mult_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
    do_mul("mult_min_1", 2'b01, 32'h8000_0000, 32'h0000_0001, -1, 1'b0);
    do_mt(2'b10, 32'h0000_1234);
    do_mt(2'b10, 32'h0000_AAAA);
    do_mt(2'b11, 32'h0000_AAAA);
    do_mul("flush_run", 2'b00, 32'd3, 32'd5, 1, 1'b0);
    do_mul("flush_wb", 2'b00, 32'd7, 32'd9, LAT, 1'b0);
    do_mul("acc_flush", 2'b00, 32'd6, 32'd7, -1, 1'b1);

    // Randomized mix of ops, flush points and accept-cycle flush.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int fa;
      op = 2'($urandom_range(0, 3));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT)) : -1;
      if (op[1]) do_mt(op, $urandom);
      else do_mul("rnd", op, $urandom, $urandom, fa, 1'($urandom));
    end

    // Asynchronous reset between edges in the middle of RUN.
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd11; req_b = 32'd13;
    step();
    req_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_ready", 64'(req_ready), 64'd1);
    check_eq("arst_mul_a", 64'(mul_a), 64'd0);
    check_hilo("arst");
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 2) step();
    check_eq("arst_no_write_busy", 64'(busy), 64'd0);
    check_hilo("arst_after");
    do_mul("post_rst", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
